// File: rtl/raster_pkg.sv
// Shared types for the triangle scanner: coordinate/vertex types, clip-width
// arithmetic type and the scanner state encoding.
package raster_pkg;

    localparam int COORD_W = 11;
    localparam int CLIP_W  = COORD_W + 1;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [CLIP_W-1:0]  clip_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN
    } scan_state_e;

    // Sign-extend a vertex coordinate into the one-bit-wider clip domain.
    function automatic clip_t sext(input coord_t c);
        return {c[COORD_W-1], c};
    endfunction

endpackage

// File: rtl/bbox_setup.sv
// Combinational bounding box of three vertices, clipped to the screen, with an
// empty flag for boxes lying entirely off-screen.
module bbox_setup
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  vertex_t            v1,
    input  vertex_t            v2,
    input  vertex_t            v3,
    output logic [COORD_W-1:0] xmin,
    output logic [COORD_W-1:0] xmax,
    output logic [COORD_W-1:0] ymin,
    output logic [COORD_W-1:0] ymax,
    output logic               empty
);

    localparam clip_t XLIM = clip_t'(SCREEN_W - 1);
    localparam clip_t YLIM = clip_t'(SCREEN_H - 1);

    function automatic clip_t min3(input clip_t a, input clip_t b, input clip_t c);
        clip_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic clip_t max3(input clip_t a, input clip_t b, input clip_t c);
        clip_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    clip_t x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        x_lo = min3(sext(v1.x), sext(v2.x), sext(v3.x));
        x_hi = max3(sext(v1.x), sext(v2.x), sext(v3.x));
        y_lo = min3(sext(v1.y), sext(v2.y), sext(v3.y));
        y_hi = max3(sext(v1.y), sext(v2.y), sext(v3.y));

        empty = (x_hi < 0) || (y_hi < 0) || (x_lo > XLIM) || (y_lo > YLIM);

        // Clamped values only matter when the box is non-empty.
        xmin = (x_lo < 0)    ? '0                 : x_lo[COORD_W-1:0];
        ymin = (y_lo < 0)    ? '0                 : y_lo[COORD_W-1:0];
        xmax = (x_hi > XLIM) ? XLIM[COORD_W-1:0]  : x_hi[COORD_W-1:0];
        ymax = (y_hi > YLIM) ? YLIM[COORD_W-1:0]  : y_hi[COORD_W-1:0];
    end

endmodule

// File: rtl/triangle_scanner.sv
// Triangle bounding-box scanner: latches a triangle, clips its box in SETUP and
// streams the box row-major over valid/ready. Optional: BACKFACE_CULL_EN.
module triangle_scanner
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      triValid,
    output logic                      triReady,
    input  logic signed [COORD_W-1:0] V1_x,
    input  logic signed [COORD_W-1:0] V1_y,
    input  logic signed [COORD_W-1:0] V2_x,
    input  logic signed [COORD_W-1:0] V2_y,
    input  logic signed [COORD_W-1:0] V3_x,
    input  logic signed [COORD_W-1:0] V3_y,
    output logic signed [COORD_W-1:0] V1_x_out,
    output logic signed [COORD_W-1:0] V1_y_out,
    output logic signed [COORD_W-1:0] V2_x_out,
    output logic signed [COORD_W-1:0] V2_y_out,
    output logic signed [COORD_W-1:0] V3_x_out,
    output logic signed [COORD_W-1:0] V3_y_out,
    output logic        [COORD_W-1:0] pixel_x,
    output logic        [COORD_W-1:0] pixel_y,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      last,
    output logic                      busy,
    output logic                      tri_dropped
);

    scan_state_e        state_q, state_d;
    vertex_t            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic               out_valid_q, out_valid_d;
    logic               last_q, last_d;
    logic               dropped_q, dropped_d;

    logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic               bb_empty;
    logic               cull;

    bbox_setup #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_bbox (
        .v1   (v1_q),
        .v2   (v2_q),
        .v3   (v3_q),
        .xmin (bb_xmin),
        .xmax (bb_xmax),
        .ymin (bb_ymin),
        .ymax (bb_ymax),
        .empty(bb_empty)
    );

`ifdef BACKFACE_CULL_EN
    clip_t              dx21, dy31, dy21, dx31;
    logic signed [23:0] prod_a, prod_b;
    logic signed [24:0] area2;

    // Twice the signed area; zero or negative means clockwise or degenerate.
    always_comb begin
        dx21   = sext(v2_q.x) - sext(v1_q.x);
        dy31   = sext(v3_q.y) - sext(v1_q.y);
        dy21   = sext(v2_q.y) - sext(v1_q.y);
        dx31   = sext(v3_q.x) - sext(v1_q.x);
        prod_a = dx21 * dy31;
        prod_b = dy21 * dx31;
        area2  = prod_a - prod_b;
        cull   = (area2 <= 0);
    end
`else
    assign cull = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d     = state_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        v3_d        = v3_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        px_d        = px_q;
        py_d        = py_q;
        out_valid_d = out_valid_q;
        dropped_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (triValid) begin
                    v1_d    = '{x: V1_x, y: V1_y};
                    v2_d    = '{x: V2_x, y: V2_y};
                    v3_d    = '{x: V3_x, y: V3_y};
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bb_empty || cull) begin
                    dropped_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    xmin_d      = bb_xmin;
                    xmax_d      = bb_xmax;
                    ymin_d      = bb_ymin;
                    ymax_d      = bb_ymax;
                    px_d        = bb_xmin;
                    py_d        = bb_ymin;
                    out_valid_d = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (outReady) begin
                    if (px_q == xmax_q && py_q == ymax_q) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (px_q == xmax_q) begin
                        px_d = xmin_q;
                        py_d = py_q + 11'd1;
                    end else begin
                        px_d = px_q + 11'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        last_d = out_valid_d && (px_d == xmax_d) && (py_d == ymax_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q     <= ST_IDLE;
            v1_q        <= '0;
            v2_q        <= '0;
            v3_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            px_q        <= px_d;
            py_q        <= py_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            dropped_q   <= dropped_d;
        end
    end

    assign triReady    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign outValid    = out_valid_q;
    assign last        = last_q;
    assign tri_dropped = dropped_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign V1_x_out    = v1_q.x;
    assign V1_y_out    = v1_q.y;
    assign V2_x_out    = v2_q.x;
    assign V2_y_out    = v2_q.y;
    assign V3_x_out    = v3_q.x;
    assign V3_y_out    = v3_q.y;

endmodule

// File: tb/tb_triangle_scanner.sv
// Scoreboard bench for triangle_scanner: a box/winding reference model fills a
// pixel queue per triangle, an independent monitor pops and compares handshakes.
module tb_triangle_scanner;
    import raster_pkg::*;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int BUDGET = 5000;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic triValid = 1'b0;
    logic triReady;
    coord_t v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
    coord_t v1x_o, v1y_o, v2x_o, v2y_o, v3x_o, v3y_o;
    logic [COORD_W-1:0] pixel_x, pixel_y;
    logic outValid, outReady = 1'b1, last, busy, tri_dropped;

    int checks = 0;
    int errors = 0;
    pix_t sb[$];
    int cur_v[6];
    int ready_mode = 0;
    int post_reset_valid = 0;

    triangle_scanner #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset(reset), .triValid(triValid), .triReady(triReady),
        .V1_x(v1x), .V1_y(v1y), .V2_x(v2x), .V2_y(v2y), .V3_x(v3x), .V3_y(v3y),
        .V1_x_out(v1x_o), .V1_y_out(v1y_o), .V2_x_out(v2x_o), .V2_y_out(v2y_o),
        .V3_x_out(v3x_o), .V3_y_out(v3y_o),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .outValid(outValid), .outReady(outReady),
        .last(last), .busy(busy), .tri_dropped(tri_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Ready driver: always high, random, or the fixed stall pattern 1,0,0,1,0,1.
    initial begin
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int pi = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: outReady = 1'b1;
                1: outReady = 1'($urandom_range(0, 1));
                default: begin
                    outReady = pat[pi];
                    pi = (pi + 1) % 6;
                end
            endcase
        end
    end

    // Monitor: pops expected pixels on each handshake and checks stall stability.
    initial begin
        bit   stalled = 1'b0;
        int   hold[10];
        pix_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_hold",
                      int'({outValid, last, pixel_x, pixel_y} == {1'b1, 1'(hold[0]), 11'(hold[1]), 11'(hold[2])}
                           && v1x_o == hold[3] && v1y_o == hold[4] && v2x_o == hold[5]
                           && v2y_o == hold[6] && v3x_o == hold[7] && v3y_o == hold[8]), 1);
            end
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("pixel_x", int'(pixel_x), e.x);
                    check("pixel_y", int'(pixel_y), e.y);
                    check("last", int'(last), int'(e.last));
                    check("vertices_out",
                          int'(v1x_o == cur_v[0] && v1y_o == cur_v[1] && v2x_o == cur_v[2]
                               && v2y_o == cur_v[3] && v3x_o == cur_v[4] && v3y_o == cur_v[5]), 1);
                end
            end
            stalled = outValid && !outReady;
            hold = '{int'(last), int'(pixel_x), int'(pixel_y), int'(v1x_o), int'(v1y_o),
                     int'(v2x_o), int'(v2y_o), int'(v3x_o), int'(v3y_o), 0};
        end
    end

    // Reference model: clipped bounding box and optional winding test, expanded
    // into the full row-major pixel list. Returns 1 if the triangle is dropped.
    function automatic bit model(input int x1, y1, x2, y2, x3, y3);
        int xl, xh, yl, yh;
        bit drop;
        xl = imin(x1, imin(x2, x3));
        xh = imax(x1, imax(x2, x3));
        yl = imin(y1, imin(y2, y3));
        yh = imax(y1, imax(y2, y3));
        drop = (xh < 0) || (yh < 0) || (xl > SW - 1) || (yl > SH - 1);
`ifdef BACKFACE_CULL_EN
        if ((x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1) <= 0) drop = 1'b1;
`endif
        if (!drop) begin
            xl = imax(xl, 0);
            yl = imax(yl, 0);
            xh = imin(xh, SW - 1);
            yh = imin(yh, SH - 1);
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xh; x++)
                    sb.push_back('{x: x, y: y, last: (x == xh && y == yh)});
        end
        return drop;
    endfunction

    task automatic issue(input int x1, y1, x2, y2, x3, y3, output bit drop);
        int n = 0;
        while (!triReady && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("tri_ready_before_issue", int'(triReady), 1);
        drop = model(x1, y1, x2, y2, x3, y3);
        cur_v = '{x1, y1, x2, y2, x3, y3};
        v1x = coord_t'(x1); v1y = coord_t'(y1);
        v2x = coord_t'(x2); v2y = coord_t'(y2);
        v3x = coord_t'(x3); v3y = coord_t'(y3);
        triValid = 1'b1;
        @(posedge clk);
        #1;
        triValid = 1'b0;
        v1x = '0; v2y = '0; v3x = '0;
        @(negedge clk);
        check("setup_busy", int'(busy), 1);
        check("setup_no_valid", int'(outValid), 0);
        @(negedge clk);
        check("first_valid_t2", int'(outValid), int'(!drop));
        check("dropped_t2", int'(tri_dropped), int'(drop));
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("scan_finished_in_budget", int'(n < BUDGET), 1);
        check("all_pixels_delivered", sb.size(), 0);
        check("tri_ready_after", int'(triReady), 1);
        check("idle_no_valid", int'(outValid), 0);
    endtask

    task automatic run_tri(input int x1, y1, x2, y2, x3, y3);
        bit drop;
        issue(x1, y1, x2, y2, x3, y3, drop);
        wait_done();
    endtask

    initial begin
        bit drop;
        // Reset held with a pending triangle: nothing may be accepted.
        triValid = 1'b1;
        v1x = 11'sd5; v1y = 11'sd5; v2x = 11'sd9; v2y = 11'sd5; v3x = 11'sd5; v3y = 11'sd9;
        repeat (3) @(negedge clk);
        check("rst_tri_ready", int'(triReady), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(outValid), 0);
        check("rst_outputs_zero",
              int'({pixel_x, pixel_y, last, tri_dropped, v1x_o, v1y_o, v2x_o, v2y_o, v3x_o, v3y_o} == '0), 1);
        triValid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(triReady && !busy && !outValid), 1);
        check("post_rst_pixels_zero", int'({pixel_x, pixel_y, v1x_o, v3y_o} == '0), 1);

        run_tri(2, 3, 5, 3, 2, 6);
        run_tri(-10, -10, 3, -5, -2, 1);
        run_tri(700, 10, 800, 20, 750, 30);
        ready_mode = 2;
        run_tri(10, 10, 11, 10, 10, 11);
        ready_mode = 0;
        run_tri(0, 0, 4, 0, 0, 4);
        run_tri(0, 0, 0, 4, 4, 0);
        run_tri(100, 100, 100, 100, 100, 100);
        run_tri(635, 475, 700, 500, 630, 470);
        run_tri(639, 479, 639, 479, 639, 479);

        // Randomised small triangles scattered over and around the screen.
        for (int i = 0; i < 30; i++) begin
            int bx, by;
            ready_mode = int'($urandom_range(0, 2));
            bx = int'($urandom_range(0, 700)) - 30;
            by = int'($urandom_range(0, 540)) - 30;
            run_tri(bx + int'($urandom_range(0, 12)) - 6, by + int'($urandom_range(0, 12)) - 6,
                    bx + int'($urandom_range(0, 12)) - 6, by + int'($urandom_range(0, 12)) - 6,
                    bx + int'($urandom_range(0, 12)) - 6, by + int'($urandom_range(0, 12)) - 6);
        end

        // Reset in the middle of a scan aborts it.
        ready_mode = 0;
        issue(0, 0, 20, 0, 0, 20, drop);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_idle", int'(triReady && !busy && !outValid), 1);
        repeat (30) begin
            @(negedge clk);
            if (outValid) post_reset_valid++;
        end
        check("abort_no_valid", post_reset_valid, 0);

        // A normal triangle still works after the abort.
        run_tri(1, 1, 3, 1, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_scanner.md
# triangle_scanner

Producer side of the rasterizer pixel handshake. Accepts one triangle (three signed 11-bit vertices) per command and computes its screen-clipped bounding box. It then streams every pixel coordinate in that box, row-major, to the rasterizer's valid/ready input, one pixel per cycle. The latched vertices are presented alongside each pixel so the rasterizer's vertex inputs stay stable for the whole scan.

## Interface
- SCREEN_W, 640, horizontal resolution; x clip range 0..SCREEN_W-1
- SCREEN_H, 480, vertical resolution; y clip range 0..SCREEN_H-1
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- triValid  in  1  triangle command valid
- triReady  out  1  block can accept a triangle (high only in IDLE)
- V1_x, V1_y, V2_x, V2_y, V3_x, V3_y  in  11 signed  triangle vertices, sampled on triangle handshake
- V1_x_out … V3_y_out  out  11 signed  latched vertices, constant from accept until return to IDLE
- pixel_x, pixel_y  out  11  current pixel coordinate
- outValid  out  1  pixel_x/pixel_y valid
- outReady  in  1  downstream (rasterizer) accepts pixel
- last  out  1  current pixel is final pixel of the triangle
- busy  out  1  state != IDLE
- tri_dropped  out  1  one-cycle pulse: triangle produced zero pixels

## Operation
- States: IDLE, SETUP, SCAN.
- IDLE: triReady=1. On triValid&&triReady, latch vertices and go to SETUP.
- SETUP (1 cycle): compute xmin/xmax/ymin/ymax as min/max of the three vertices. Clip to [0,SCREEN_W-1] / [0,SCREEN_H-1] with signed compares.
  - Box empty (xmax<0, ymax<0, xmin>SCREEN_W-1 or ymin>SCREEN_H-1): pulse tri_dropped, go to IDLE.
  - Otherwise: load pixel_x=xmin, pixel_y=ymin, assert outValid, go to SCAN.
- SCAN: on outValid&&outReady:
  - pixel_x==xmax and pixel_y==ymax: deassert outValid, go to IDLE.
  - pixel_x==xmax otherwise: pixel_x=xmin, pixel_y+=1.
  - Otherwise: pixel_x+=1.
- last = outValid && pixel_x==xmax && pixel_y==ymax. Single-pixel box: first pixel has last=1.
- Stall: while outValid&&!outReady, pixel_x, pixel_y, last and V*_out hold.
- Degenerate triangle (all vertices equal, on-screen): scans exactly one pixel.
- Clip arithmetic uses 12-bit signed internally. Pixel outputs are unsigned 11-bit and always in range.

## Timing
- Reset (reset==0 at a clock edge):
  - state=IDLE, triReady=1, outValid=0, last=0, busy=0, tri_dropped=0
  - pixel_x=pixel_y=0, V*_out=0
- Reset mid-scan aborts immediately; no further outValid.
- Triangle accepted at edge T: SETUP during T+1. First outValid at T+2 (or tri_dropped pulse at T+2).
- Throughput: 1 pixel/cycle with outReady held high. N-pixel box finishes N cycles after first outValid.
- Final handshake at edge E: IDLE and triReady=1 from E+1. Two idle cycles minimum between triangles.
- triReady is a combinational decode of state. outValid and the pixel outputs are registered.

## Configuration
- BACKFACE_CULL_EN defined:
  - SETUP also computes area2 = (V2_x-V1_x)*(V3_y-V1_y) - (V2_y-V1_y)*(V3_x-V1_x): 12-bit diffs, 24-bit products, 25-bit signed result.
  - area2 <= 0: tri_dropped pulse, return to IDLE, no pixels emitted. SETUP latency unchanged.
- BACKFACE_CULL_EN undefined: no area logic; every triangle with a non-empty clipped box is scanned regardless of winding.

## Structure
- Package raster_pkg:
  - COORD_W=11
  - typedef logic signed [COORD_W-1:0] coord_t
  - typedef struct vertex_t {x,y}
  - scanner state enum typedef
- Sub-module bbox_setup (combinational): three vertices plus screen params in; clipped xmin/xmax/ymin/ymax and empty flag out. Registered in SETUP by the top level.

## Test plan
- Reset with triValid=1 -> no accept while reset=0. After release: triReady=1, outValid=0, all outputs 0.
- Triangle (2,3),(5,3),(2,6), outReady=1 -> 16 pixels (2..5 × 3..6) row-major, first at T+2; last only on (5,6); triReady high the cycle after.
- Triangle (-10,-10),(3,-5),(-2,1) -> clipped box x 0..3, y 0..1; 8 pixels; no negative coordinates emitted.
- Triangle (700,10),(800,20),(750,30) with SCREEN_W=640 -> tri_dropped pulse at T+2, no outValid.
- 2×2 box with outReady toggling 1,0,0,1,0,1… -> pixels and V*_out stable during stalls; exactly 4 handshakes; order unchanged.
- BACKFACE_CULL_EN: (0,0),(4,0),(0,4) scanned; (0,0),(0,4),(4,0) dropped. Without the macro: both scanned, 25 pixels each.
